// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through read port.
module fifo_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_rd_acc;
  logic w_wr_acc;

  // A write into a full FIFO is still taken when the same cycle frees a slot.
  assign w_rd_acc = ren && (r_count != '0);
  assign w_wr_acc = wen && ((r_count != FULL_COUNT) || w_rd_acc);

  assign empty        = (r_count == '0);
  assign full         = (r_count == FULL_COUNT);
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_COUNT);
  assign almost_empty = (r_count <= AE_COUNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count     <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      r_overflow  <= wen && !w_wr_acc;
      r_underflow <= ren && !w_rd_acc;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [WIDTH-1:0] r_rdata;

      // Head word is captured on the pop edge and held until the next pop.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[r_rd_ptr];
        end
      end

      assign rdata = r_rdata;
    end else begin : g_fwft_read
      assign rdata = empty ? '0 : r_mem[r_rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a standard-read instance checked against a queue
// scoreboard every cycle, plus a first-word-fall-through instance.
module tb_fifo_param;

  logic clk;

  logic       rst0, wen0, ren0;
  logic [3:0] wd0, rd0;
  logic       emp0, full0, af0, ae0, ovf0, unf0;
  logic [4:0] cnt0;

  logic       rst1, wen1, ren1;
  logic [3:0] wd1, rd1;
  logic       emp1, full1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt1;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] sb[$];
  int         m_count;
  logic [3:0] m_rdata;
  logic       m_ovf, m_unf;

  fifo_param #(.WIDTH(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut_std (
    .clk(clk), .reset(rst0), .wen(wen0), .wdata(wd0), .ren(ren0), .rdata(rd0),
    .empty(emp0), .full(full0), .count(cnt0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_param #(.WIDTH(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut_fwft (
    .clk(clk), .reset(rst1), .wen(wen1), .wdata(wd1), .ren(ren1), .rdata(rd1),
    .empty(emp1), .full(full1), .count(cnt1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the standard instance; the expected state comes from the queue model.
  task automatic step0(input string tag, input logic w, input logic [3:0] d, input logic r);
    logic ra, wa;
    ra = r && (m_count > 0);
    wa = w && ((m_count < 16) || ra);
    if (ra) m_rdata = sb.pop_front();
    if (wa) sb.push_back(d);
    m_count = m_count + int'(wa) - int'(ra);
    m_ovf = w && !wa;
    m_unf = r && !ra;
    wen0 = w; wd0 = d; ren0 = r;
    @(posedge clk); #1;
    $display("%s wen=%0b wdata=%0h ren=%0b -> rdata=%0h count=%0d e=%0b f=%0b ae=%0b af=%0b ovf=%0b unf=%0b",
             tag, w, d, r, rd0, cnt0, emp0, full0, ae0, af0, ovf0, unf0);
    chk({tag, "/count"}, 32'(cnt0), 32'(m_count));
    chk({tag, "/empty"}, 32'(emp0), 32'(m_count == 0));
    chk({tag, "/full"}, 32'(full0), 32'(m_count == 16));
    chk({tag, "/almost_full"}, 32'(af0), 32'(m_count >= 14));
    chk({tag, "/almost_empty"}, 32'(ae0), 32'(m_count <= 2));
    chk({tag, "/overflow"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, "/underflow"}, 32'(unf0), 32'(m_unf));
    chk({tag, "/rdata"}, 32'(rd0), 32'(m_rdata));
  endtask

  task automatic step1(input string tag, input logic w, input logic [3:0] d, input logic r);
    wen1 = w; wd1 = d; ren1 = r;
    @(posedge clk); #1;
    $display("%s wen=%0b wdata=%0h ren=%0b -> rdata=%0h count=%0d e=%0b unf=%0b",
             tag, w, d, r, rd1, cnt1, emp1, unf1);
  endtask

  initial begin
    rst0 = 1'b1; wen0 = 1'b0; ren0 = 1'b0; wd0 = '0;
    rst1 = 1'b1; wen1 = 1'b0; ren1 = 1'b0; wd1 = '0;
    m_count = 0; m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset held with both requests active: nothing may move.
    for (int i = 0; i < 5; i++) begin
      wen0 = 1'b1; ren0 = 1'b1; wd0 = 4'(i + 3);
      @(posedge clk); #1;
      $display("reset[%0d] -> rdata=%0h count=%0d e=%0b f=%0b ovf=%0b unf=%0b",
               i, rd0, cnt0, emp0, full0, ovf0, unf0);
      chk("reset/flags", 32'({emp0, full0, ovf0, unf0, ae0, af0}), 32'(6'b100010));
      chk("reset/count", 32'(cnt0), 32'd0);
      chk("reset/rdata", 32'(rd0), 32'd0);
    end
    rst0 = 1'b0;
    step0("idle", 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 18; i++) step0($sformatf("fill[%0d]", i), 1'b1, 4'(i), 1'b0);
    chk("fill/final_full", 32'(full0), 32'd1);

    for (int i = 0; i < 18; i++) step0($sformatf("drain[%0d]", i), 1'b0, 4'h0, 1'b1);
    chk("drain/held_rdata", 32'(rd0), 32'hF);

    for (int i = 0; i < 16; i++) step0($sformatf("refill[%0d]", i), 1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 4; i++) step0($sformatf("rw_full[%0d]", i), 1'b1, 4'hA, 1'b1);
    chk("rw_full/count", 32'(cnt0), 32'd16);
    for (int i = 0; i < 16; i++) step0($sformatf("drain2[%0d]", i), 1'b0, 4'h0, 1'b1);
    chk("drain2/last", 32'(rd0), 32'hA);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        step0($sformatf("wrap%0d_w[%0d]", r, i), 1'b1, 4'((r * 5 + i) % 16), 1'b0);
        chk("wrap/max_count", 32'(cnt0 <= 5'd10), 32'd1);
      end
      for (int i = 0; i < 10; i++) step0($sformatf("wrap%0d_r[%0d]", r, i), 1'b0, 4'h0, 1'b1);
    end

    // First-word-fall-through instance.
    step1("fwft_reset", 1'b1, 4'h3, 1'b1);
    chk("fwft/reset_count", 32'(cnt1), 32'd0);
    chk("fwft/reset_rdata", 32'(rd1), 32'd0);
    rst1 = 1'b0;
    step1("fwft_wr5", 1'b1, 4'h5, 1'b0);
    chk("fwft/head_visible", 32'(rd1), 32'h5);
    chk("fwft/count1", 32'(cnt1), 32'd1);
    step1("fwft_idle", 1'b0, 4'h0, 1'b0);
    chk("fwft/head_held", 32'(rd1), 32'h5);
    step1("fwft_pop", 1'b0, 4'h0, 1'b1);
    chk("fwft/empty_after_pop", 32'(emp1), 32'd1);
    chk("fwft/rdata_zero", 32'(rd1), 32'd0);
    step1("fwft_rw_empty", 1'b1, 4'h9, 1'b1);
    chk("fwft/underflow", 32'(unf1), 32'd1);
    chk("fwft/count_after_rw", 32'(cnt1), 32'd1);
    chk("fwft/new_head", 32'(rd1), 32'h9);
    step1("fwft_idle2", 1'b0, 4'h0, 1'b0);
    chk("fwft/underflow_clear", 32'(unf1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's fixed 4-bit FIFO, generalised in data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It sits between single-clock producer/consumer blocks as the standard buffering primitive.

Parameters:
WIDTH, 4, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wen  input  1  write request
wdata  input  WIDTH  write data
ren  input  1  read request
rdata  output  WIDTH  read data
empty  output  1  no entries stored
full  output  1  DEPTH entries stored
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
overflow  output  1  one-cycle pulse: write rejected because full
underflow  output  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (reset=1 at a clock edge): pointers and count go to 0. Outputs are empty=1, full=0, count=0, almost_empty=1, almost_full=0 (or 1 if AF_LEVEL==0 is disallowed), overflow=0, underflow=0, rdata=0. Memory contents are not cleared. Reset overrides wen/ren in the same cycle. Reset mid-operation discards all stored data.
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accept: wen && (!full || read_accept). Accepted data is stored at wr_ptr, and wr_ptr increments.
- Read accept: ren && !empty. rd_ptr increments.
- Simultaneous ren+wen when full: both are accepted, count is unchanged, no overflow.
- Simultaneous ren+wen when empty: the write is accepted and the read is rejected. underflow pulses, and the count becomes 1. There is no bypass of write data to rdata.
- Count update: count += write_accept - read_accept. Flags are combinational from the registered count: empty = (count==0), full = (count==DEPTH).
- overflow: asserted for the cycle after the edge where wen && !write_accept. underflow is the same for ren && !read_accept. Both are registered and clear the following cycle unless the condition repeats.
- FWFT=0: rdata is registered. On an accepted read, rdata <= mem[rd_ptr], visible the cycle after ren. rdata holds its value on cycles with no accepted read, including rejected reads.
- FWFT=1: rdata = mem[rd_ptr] whenever !empty, and 0 when empty. The head word is visible without ren; ren pops it and the next word appears the following cycle. A word written into an empty FIFO appears on rdata one cycle after the write edge.
- Ordering: strict first-in, first-out. No data loss except rejected writes.
- Pointer wrap: after DEPTH writes and DEPTH reads, the pointers return to 0 and operation continues seamlessly.

Test Plan:
- Reset hold: reset=1 for 5 cycles with wen=ren=1 -> empty=1, full=0, count=0, rdata=0, overflow=underflow=0 throughout.
- Fill with overflow (WIDTH=4, DEPTH=16): write 0..17 on consecutive cycles -> count steps 1..16. full=1 after the 16th write. almost_full=1 from count 14. overflow pulses after the writes of 16 and 17. Contents are 0..15.
- Drain with underflow (FWFT=0): 18 consecutive ren -> rdata reads 0..15, each one cycle after its ren. empty=1 after the 16th read. almost_empty=1 from count 2. underflow pulses on the 17th and 18th read. rdata holds 15.
- Simultaneous read and write at full: fill 16, then wen=ren=1 with wdata=0xA for 4 cycles -> count stays 16, no overflow, and reads return 0,1,2,3. A subsequent drain ends with A,A,A,A.
- Wrap-around: 3 rounds of writing 10 words then reading 10 -> all data in order, and count never exceeds 10.
- FWFT=1: write 0x5 into empty -> rdata=0x5 on the next cycle with ren=0. ren=1 pops it -> empty=1 and rdata=0. wen+ren into empty -> underflow=1, count=1.
